// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated TX FIFO; frames go out back-to-back while data is queued.
// Optional parity bit: define UART_TX_PARITY_EN (PARITY_ODD selects odd parity).
module uart_tx_fifo #(
  parameter int WAIT       = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  output logic                   uart_tx,
  output logic                   busy,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(WAIT);
  localparam int IW = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [PW-1:0]        r_level;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_overflow;

  state_t               r_state;
  logic [CW-1:0]        r_bit_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_bit_last;
  logic                 w_stop_last;
  logic [PW-1:0]        w_wr_ptr_nxt;
  logic [PW-1:0]        w_rd_ptr_nxt;
  logic [PW-1:0]        w_level_nxt;
  logic [DATA_BITS-1:0] w_head;

`ifdef UART_TX_PARITY_EN
  logic                 r_parity;

  function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
    logic [31:0] w_odd;
    w_odd = PARITY_ODD;
    return (^d) ^ w_odd[0];
  endfunction
`endif

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_bit_last = (r_bit_cnt == CW'(WAIT - 1));

  // Push/pop decisions and next-state FIFO pointers; a pop never frees room for a same-cycle push.
  always_comb begin
    w_push       = wr_en & ~r_full;
    w_stop_last  = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if ((r_state == S_STOP) && w_bit_last && (r_idx == IW'(STOP_BITS - 1))) begin
      w_stop_last = 1'b1;
    end else begin
      w_stop_last = 1'b0;
    end
    w_pop = ~r_empty & ((r_state == S_IDLE) | w_stop_last);
    if (w_push) begin
      w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    end else begin
      w_wr_ptr_nxt = r_wr_ptr;
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end else begin
      w_rd_ptr_nxt = r_rd_ptr;
    end
    w_level_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
  end

  // FIFO storage, pointers and registered status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_BITS{1'b0}};
      end
      r_wr_ptr   <= {PW{1'b0}};
      r_rd_ptr   <= {PW{1'b0}};
      r_level    <= {PW{1'b0}};
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
      end
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= (w_level_nxt == PW'(DEPTH));
      r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      if (wr_en && r_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Frame sequencer; the line level is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= {CW{1'b0}};
      r_idx     <= {IW{1'b0}};
      r_shift   <= {DATA_BITS{1'b0}};
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt <= {CW{1'b0}};
          r_idx     <= {IW{1'b0}};
          if (w_pop) begin
            r_state <= S_START;
            r_shift <= w_head;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity <= f_parity(w_head);
`endif
          end else begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_last) begin
            r_state   <= S_DATA;
            r_bit_cnt <= {CW{1'b0}};
            r_idx     <= {IW{1'b0}};
            r_tx      <= r_shift[0];
            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_bit_last) begin
            r_bit_cnt <= {CW{1'b0}};
            if (r_idx == IW'(DATA_BITS - 1)) begin
              r_idx <= {IW{1'b0}};
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_tx    <= r_parity;
`else
              r_state <= S_STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_idx   <= r_idx + IW'(1);
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (w_bit_last) begin
            r_state   <= S_STOP;
            r_bit_cnt <= {CW{1'b0}};
            r_idx     <= {IW{1'b0}};
            r_tx      <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_bit_last) begin
            r_bit_cnt <= {CW{1'b0}};
            if (w_stop_last) begin
              r_idx <= {IW{1'b0}};
              // Zero-gap chaining: the next start bit follows the last stop clock directly.
              if (w_pop) begin
                r_state <= S_START;
                r_shift <= w_head;
                r_tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
                r_parity <= f_parity(w_head);
`endif
              end else begin
                r_state <= S_IDLE;
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_bit_cnt <= {CW{1'b0}};
          r_idx     <= {IW{1'b0}};
          r_tx      <= 1'b1;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx  = r_tx;
  assign busy     = r_busy;
  assign empty    = r_empty;
  assign full     = r_full;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (WAIT=4, 8 data bits, DEPTH=4; second instance with 2 stop bits).
module tb_uart_tx_fifo;

  localparam int WAIT = 4;
  localparam int DB   = 8;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int   FR   = (1 + DB + P + 1) * WAIT;
  localparam logic PODD = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uart_tx, busy, empty, full, overflow;
  logic [2:0] level;

  logic       wr_en2 = 1'b0;
  logic [7:0] wr_data2 = 8'h00;
  logic       uart_tx2, busy2, empty2, full2, overflow2;
  logic [2:0] level2;

  int checks = 0;
  int errors = 0;
  int bad;
  int n;

  uart_tx_fifo #(.WAIT(WAIT), .DATA_BITS(DB), .STOP_BITS(1), .DEPTH(4), .PARITY_ODD(0)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .uart_tx(uart_tx),
    .busy(busy), .empty(empty), .full(full), .level(level), .overflow(overflow));

  uart_tx_fifo #(.WAIT(WAIT), .DATA_BITS(DB), .STOP_BITS(2), .DEPTH(4), .PARITY_ODD(0)) u_dut2 (
    .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_data(wr_data2), .uart_tx(uart_tx2),
    .busy(busy2), .empty(empty2), .full(full2), .level(level2), .overflow(overflow2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line level at frame clock t for byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int t);
    int b;
    b = t / WAIT;
    if (b == 0) return 1'b0;
    else if (b <= DB) return d[b-1];
    else if (P == 1 && b == DB + 1) return (^d) ^ PODD;
    else return 1'b1;
  endfunction

  // Called at the negedge of frame clock first_t; returns at the negedge after the last frame clock.
  task automatic run_frame(input logic [7:0] d, input int first_t, input string tag);
    int nbad;
    int nbusy;
    nbad = 0;
    nbusy = 0;
    for (int t = first_t; t < FR; t++) begin
      if (uart_tx !== exp_bit(d, t)) nbad++;
      if (busy !== 1'b1) nbusy++;
      @(negedge clk);
    end
    chk({tag, "_bits"}, nbad, 0);
    chk({tag, "_busy"}, nbusy, 0);
  endtask

  initial begin
    // 1: reset values, then 100 idle clocks
    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || empty !== 1'b1 || full !== 1'b0 ||
          level !== 3'd0 || overflow !== 1'b0) bad++;
    end
    chk("idle_hold", bad, 0);

    // 2: single byte 0x5A
    wr_data = 8'h5A; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t2_pre_tx", uart_tx, 1);
    chk("t2_pre_busy", busy, 0);
    chk("t2_pre_level", level, 1);
    @(negedge clk);
    chk("t2_empty_start", empty, 1);
    run_frame(8'h5A, 0, "t2");
    chk("t2_busy_end", busy, 0);
    chk("t2_tx_end", uart_tx, 1);
    chk("t2_empty_end", empty, 1);

    // 3: three bytes back-to-back
    wr_data = 8'h01; wr_en = 1'b1;
    @(negedge clk);
    chk("t3_level_a", level, 1);
    wr_data = 8'h02;
    @(negedge clk);
    chk("t3_start_tx", uart_tx, 0);
    chk("t3_level_b", level, 1);
    wr_data = 8'h03;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t3_level_c", level, 2);
    run_frame(8'h01, 1, "t3_f1");
    chk("t3_level_d", level, 1);
    run_frame(8'h02, 0, "t3_f2");
    chk("t3_level_e", level, 0);
    run_frame(8'h03, 0, "t3_f3");
    chk("t3_busy_end", busy, 0);
    chk("t3_empty_end", empty, 1);

    // 4: six pushes, sixth dropped
    for (int i = 0; i < 6; i++) begin
      wr_data = 8'h10 + 8'(i); wr_en = 1'b1;
      @(negedge clk);
      if (i == 4) begin
        chk("t4_full", full, 1);
        chk("t4_level", level, 4);
        chk("t4_ovf_pre", overflow, 0);
      end
    end
    wr_en = 1'b0;
    chk("t4_ovf", overflow, 1);
    chk("t4_level_kept", level, 4);
    run_frame(8'h10, 4, "t4_f1");
    run_frame(8'h11, 0, "t4_f2");
    run_frame(8'h12, 0, "t4_f3");
    run_frame(8'h13, 0, "t4_f4");
    run_frame(8'h14, 0, "t4_f5");
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy !== 1'b0 || uart_tx !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("t4_no_6th", bad, 0);
    chk("t4_ovf_sticky", overflow, 1);

    // 5: reset during data bit 3 with two bytes queued
    wr_data = 8'h20; wr_en = 1'b1;
    @(negedge clk);
    wr_data = 8'h21;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (16) @(negedge clk);
    chk("t5_level_pre", level, 2);
    chk("t5_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    chk("t5_tx", uart_tx, 1);
    chk("t5_busy", busy, 0);
    chk("t5_level", level, 0);
    chk("t5_ovf", overflow, 0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || uart_tx !== 1'b1) bad++;
    end
    chk("t5_quiet", bad, 0);

    // 6: frame length / parity for 0x5A, then the 2-stop-bit instance
    wr_data = 8'h5A; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    run_frame(8'h5A, 0, "t6");
    chk("t6_busy_end", busy, 0);

    wr_data2 = 8'h5A; wr_en2 = 1'b1;
    @(negedge clk);
    wr_en2 = 1'b0;
    @(negedge clk);
    n = 0;
    bad = 0;
    while (busy2 === 1'b1 && n < 400) begin
      if (uart_tx2 !== exp_bit(8'h5A, n)) bad++;
      n++;
      @(negedge clk);
    end
    chk("t6_stop2_len", n, FR + WAIT);
    chk("t6_stop2_bits", bad, 0);
    chk("t6_stop2_tx_end", uart_tx2, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
